td1_eval_arbiter: RTL
=====================

# td1_eval_arbiter

Round-robin arbiter and two-stage pipeline that shares one instance of the `td1` evaluation datapath among `NREQ` requesters. The datapath is the NAND2→AND2→AND4/BUF cone. Each requester presents a 6-bit operand vector with a valid/ready handshake. The block registers the granted operands, evaluates the datapath, and returns the 2-bit result tagged with the requester index over a single valid/ready response port. It sits between requester logic and the shared evaluation cone, and is the only driver of that cone.

## Interface
- `NREQ`, default 4: number of requesters, legal range 2..16.
- `IDW`, default `$clog2(NREQ)`: width of the requester tag.
- `CNTW`, default 16: width of the delivered-response counter.
- `clk` input, 1 bit: the single clock. All state updates on its rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `req_valid` input, `NREQ` bits: per-requester request valid.
- `req_opnd` input, `NREQ*6` bits: requester i occupies `[6i+5:6i]`, bit order `{a6,a5,a4,a3,a2,a1}`.
- `req_ready` output, `NREQ` bits: per-requester grant. At most one bit is high.
- `rsp_valid` output, 1 bit: the response holds a result.
- `rsp_ready` input, 1 bit: the consumer accepts the response.
- `rsp_id` output, `IDW` bits: index of the requester that owns the result.
- `rsp_y` output, 2 bits: `{y2,y1}`.
- `done_cnt` output, `CNTW` bits: count of delivered responses; wraps modulo 2^CNTW.
- `busy` output, 1 bit: high when either pipeline stage is valid.

## Operation
- Evaluation function:
  - n1 = ~(a1 & a2)
  - y1 = n1 & a3
  - y2 = a6 & a4 & a5 & y1
- Stage S1 holds `s1_v`, `s1_opnd[5:0]` and `s1_id`.
- Stage S2 holds `s2_v`, `s2_y[1:0]` and `s2_id`.
- Outputs: `rsp_valid` = `s2_v`, `rsp_y` = `s2_y`, `rsp_id` = `s2_id`.
- Advance rules:
  - `s2_load` = `s1_v & (~s2_v | rsp_ready)`.
  - `s1_free` = `~s1_v | s2_load`.
- Arbitration:
  - Scan `req_valid` starting at requester `last+1` (mod `NREQ`).
  - The first valid requester i wins. `req_ready[i]` = `s1_free`; all other `req_ready` bits are 0.
  - `req_ready` depends combinationally on `req_valid`, `rsp_ready` and state.
  - A requester must not make `req_valid` depend on `req_ready`.
- Transfer: a request fires when `req_valid[i] & req_ready[i]`. On that edge:
  - S1 loads the operands of requester i.
  - `s1_id` = i.
  - `last` = i.
- S1 with no transfer:
  - If S1 is advancing and no request fires, `s1_v` goes to 0.
  - If S1 is stalled, it holds its contents.
- S2 load: on `s2_load`, S2 takes `eval(s1_opnd)` and `s1_id`.
- S2 drain: if `rsp_valid & rsp_ready` and `s1_v` = 0, `s2_v` goes to 0.
- `done_cnt` increments by 1 on every `rsp_valid & rsp_ready`, wrapping from all-ones to 0.
- Stability: while `rsp_valid & ~rsp_ready`, the values of `rsp_y` and `rsp_id` must not change.
- Fairness: while a requester holds `req_valid`, it is granted within `NREQ` grants.
- No drops, no duplicates: each accepted request produces exactly one response, and responses come out in acceptance order.
- Reset (asynchronous, at any time, including mid-transfer):
  - `s1_v` = `s2_v` = 0.
  - All data and id registers = 0.
  - `last` = `NREQ-1`, so requester 0 has first priority.
  - `done_cnt` = 0.
  - Outputs therefore reset to: `rsp_valid` 0, `rsp_y` 0, `rsp_id` 0, `busy` 0, `req_ready` all 0.
  - Requests in flight at reset are discarded.

## Timing
- Latency: a request accepted at edge N gives `rsp_valid` = 1 after edge N+1, with no backpressure.
- Throughput: 1 request per cycle while `rsp_ready` = 1.
- Backpressure:
  - With `rsp_ready` held at 0, at most 2 requests are accepted: one in S1 and one in S2.
  - After that, `req_ready` = 0.
  - In the cycle `rsp_ready` returns to 1, `req_ready` is reasserted in the same cycle.
- Simultaneous events: a response handshake, an S1→S2 move and a new grant can all happen on the same edge.
- Only `req_ready` may be combinational; every other output is registered.

## Structure
- Package `td1_arb_pkg` holds:
  - `localparam OPW = 6`.
  - `typedef logic [5:0] opnd_t`.
  - `typedef logic [1:0] res_t`.
  - Bit-position constants `A1..A6`.
- Sub-module `td1_eval` is the purely combinational evaluation cone (`opnd_t` in, `res_t` out). It sits between S1 and S2.
- The round-robin search is a function inside the top module.

## Test plan
- Single request: reset, then requester 0 sends `opnd` = 6'b111100 → `rsp_valid` two edges later with `rsp_y` = 2'b11, `rsp_id` = 0, then `done_cnt` = 1.
- Function vectors: with `rsp_ready` = 1, send 6'b111111, 6'b011100, 6'b000000 → `rsp_y` = 2'b00, 2'b01, 2'b00 in order.
- Round-robin: all 4 requesters valid continuously → grants cycle 0,1,2,3,0,… with one `req_ready` bit per cycle, and each `rsp_id` matches.
- Backpressure: `rsp_ready` = 0 for 10 cycles with requests pending → exactly 2 accepted, `rsp` outputs stable, `busy` = 1. Release `rsp_ready` → both delivered in order with no loss.
- Reset mid-operation: assert `rst_n` = 0 while S1 and S2 are both valid → all outputs zero immediately. After release, requester 0 is granted first.
- Counter wrap: with `CNTW` = 4, complete 17 responses → `done_cnt` = 1.

Source files
------------

// File: rtl/td1_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : td1_arb_pkg
// Purpose  : Shared types and operand bit positions for the td1 evaluation
//            arbiter and its combinational evaluation cone.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
package td1_arb_pkg;

   localparam int OPW = 6;

   typedef logic [5:0] opnd_t;
   typedef logic [1:0] res_t;

   // Operand vector is packed {a6,a5,a4,a3,a2,a1}
   localparam int A1 = 0;
   localparam int A2 = 1;
   localparam int A3 = 2;
   localparam int A4 = 3;
   localparam int A5 = 4;
   localparam int A6 = 5;

endpackage
`default_nettype wire

// File: rtl/td1_eval.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : td1_eval
// Purpose  : Purely combinational NAND2 -> AND2 -> AND4/BUF evaluation cone.
//            Result is packed {y2,y1}.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module td1_eval
   import td1_arb_pkg::*;
(
   input  opnd_t opnd,
   output res_t  y
);

   logic w_n1;
   logic w_y1;
   logic w_y2;

   assign w_n1 = ~(opnd[A1] & opnd[A2]);
   assign w_y1 = w_n1 & opnd[A3];
   assign w_y2 = opnd[A6] & opnd[A4] & opnd[A5] & w_y1;
   assign y    = {w_y2, w_y1};

endmodule
`default_nettype wire

// File: rtl/td1_eval_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : td1_eval_arbiter
// Purpose  : Round-robin arbiter feeding a two-stage pipeline around one
//            shared td1 evaluation cone. Results return tagged with the
//            requester index over a single valid/ready response port.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module td1_eval_arbiter
   import td1_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ),
   parameter int CNTW = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*6-1:0] req_opnd,
   output logic [NREQ-1:0]   req_ready,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [1:0]        rsp_y,
   output logic [CNTW-1:0]   done_cnt,
   output logic              busy
);

   // Pointer reset value gives requester 0 first priority
   localparam logic [IDW-1:0] c_LAST_INIT = IDW'(NREQ - 1);

   logic            r_s1_v;
   opnd_t           r_s1_opnd;
   logic [IDW-1:0]  r_s1_id;
   logic            r_s2_v;
   res_t            r_s2_y;
   logic [IDW-1:0]  r_s2_id;
   logic [IDW-1:0]  r_last;
   logic [CNTW-1:0] r_done_cnt;

   logic            w_s2_load;
   logic            w_s1_free;
   logic [IDW:0]    w_pick;
   logic            w_found;
   logic [IDW-1:0]  w_win;
   logic            w_fire;
   logic            w_rsp_hs;
   opnd_t           w_sel_opnd;
   res_t            w_eval_y;

   // Returns {found, index} of the first valid requester after 'last'.
   // Scanning from the farthest candidate down lets the nearest one win.
   function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] valid,
                                            input logic [IDW-1:0]  last);
      logic [IDW:0]   res;
      logic [IDW-1:0] idx;
      int             j;
      res = '0;
      for (int k = NREQ; k >= 1; k--) begin
         j   = (int'(last) + k) % NREQ;
         idx = j[IDW-1:0];
         if (valid[idx]) begin
            res = {1'b1, idx};
         end
      end
      return res;
   endfunction

   assign w_s2_load = r_s1_v & (~r_s2_v | rsp_ready);
   assign w_s1_free = ~r_s1_v | w_s2_load;
   assign w_pick    = rr_pick(req_valid, r_last);
   assign w_found   = w_pick[IDW];
   assign w_win     = w_pick[IDW-1:0];
   assign w_fire    = w_found & w_s1_free;
   assign w_rsp_hs  = r_s2_v & rsp_ready;

   // Grant decode and operand mux; grants are suppressed while in reset
   always_comb begin
      w_sel_opnd = '0;
      req_ready  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_win == IDW'(i)) begin
            w_sel_opnd   = req_opnd[i*OPW +: OPW];
            req_ready[i] = w_found & w_s1_free & rst_n;
         end
      end
   end

   td1_eval u_eval (
      .opnd (r_s1_opnd),
      .y    (w_eval_y)
   );

   // Stage S1: capture the granted request, empty when advancing without one
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_v    <= 1'b0;
         r_s1_opnd <= '0;
         r_s1_id   <= '0;
         r_last    <= c_LAST_INIT;
      end else if (w_fire) begin
         r_s1_v    <= 1'b1;
         r_s1_opnd <= w_sel_opnd;
         r_s1_id   <= w_win;
         r_last    <= w_win;
      end else if (w_s2_load) begin
         r_s1_v    <= 1'b0;
      end
   end

   // Stage S2: take the evaluated result, empty once drained with nothing behind
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_v  <= 1'b0;
         r_s2_y  <= '0;
         r_s2_id <= '0;
      end else if (w_s2_load) begin
         r_s2_v  <= 1'b1;
         r_s2_y  <= w_eval_y;
         r_s2_id <= r_s1_id;
      end else if (w_rsp_hs) begin
         r_s2_v  <= 1'b0;
      end
   end

   // Delivered-response counter, wraps naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_done_cnt <= '0;
      end else if (w_rsp_hs) begin
         r_done_cnt <= r_done_cnt + CNTW'(1);
      end
   end

   assign rsp_valid = r_s2_v;
   assign rsp_y     = r_s2_y;
   assign rsp_id    = r_s2_id;
   assign done_cnt  = r_done_cnt;
   assign busy      = r_s1_v | r_s2_v;

endmodule
`default_nettype wire
